// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin front end for an APB master: grant, latch, issue, wait, respond.
// Optional WAIT-state timeout is compiled in with `define APB_ARB_TIMEOUT_EN.
module apb_req_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int STROBE_WIDTH   = 4,
    parameter int SLAVES_NUM     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [1:0]                req,
    input  logic [2*ADDR_WIDTH-1:0]   req_addr,
    input  logic [2*DATA_WIDTH-1:0]   req_wdata,
    input  logic [1:0]                req_write,
    input  logic [2*SLAVES_NUM-1:0]   req_sel,
    input  logic [2*STROBE_WIDTH-1:0] req_strb,
    output logic [1:0]                ack,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_slverr,
    output logic                      busy,
    output logic                      m_Transfer,
    output logic [ADDR_WIDTH-1:0]     m_ADDR,
    output logic [DATA_WIDTH-1:0]     m_DATA,
    output logic                      m_WRITE,
    output logic [SLAVES_NUM-1:0]     m_SEL,
    output logic [STROBE_WIDTH-1:0]   m_STROB,
    output logic [2:0]                m_PROT,
    input  logic                      m_done,
    input  logic [DATA_WIDTH-1:0]     m_rdata,
    input  logic                      m_slverr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    function automatic logic is_onehot(input logic [SLAVES_NUM-1:0] v);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < SLAVES_NUM; i++) begin
            multi = multi | (seen & v[i]);
            seen  = seen | v[i];
        end
        return seen & ~multi;
    endfunction

    state_t                    state_r, state_nxt_s;
    logic                      last_grant_r, grant_r, grant_nxt_s, grant_valid_s;
    logic                      resp_load_s, resp_err_s;
    logic [DATA_WIDTH-1:0]     resp_data_s;
    logic [ADDR_WIDTH-1:0]     addr_mux_s;
    logic [DATA_WIDTH-1:0]     wdata_mux_s;
    logic [SLAVES_NUM-1:0]     sel_mux_s;
    logic [STROBE_WIDTH-1:0]   strb_mux_s;
    logic                      write_mux_s;

    logic [1:0]                ack_r;
    logic [DATA_WIDTH-1:0]     rsp_rdata_r;
    logic                      rsp_slverr_r, busy_r, m_transfer_r, m_write_r;
    logic [ADDR_WIDTH-1:0]     m_addr_r;
    logic [DATA_WIDTH-1:0]     m_data_r;
    logic [SLAVES_NUM-1:0]     m_sel_r;
    logic [STROBE_WIDTH-1:0]   m_strb_r;

    assign addr_mux_s  = grant_nxt_s ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]     : req_addr[ADDR_WIDTH-1:0];
    assign wdata_mux_s = grant_nxt_s ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]    : req_wdata[DATA_WIDTH-1:0];
    assign sel_mux_s   = grant_nxt_s ? req_sel[2*SLAVES_NUM-1:SLAVES_NUM]      : req_sel[SLAVES_NUM-1:0];
    assign strb_mux_s  = grant_nxt_s ? req_strb[2*STROBE_WIDTH-1:STROBE_WIDTH] : req_strb[STROBE_WIDTH-1:0];
    assign write_mux_s = req_write[grant_nxt_s];

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_r;

    // Counts cycles spent in WAIT; cleared in every other state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == WAIT) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
        end else begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end
    end
`endif

    // Next-state, grant choice and response source selection.
    always_comb begin
        state_nxt_s   = state_r;
        grant_nxt_s   = grant_r;
        grant_valid_s = 1'b0;
        resp_load_s   = 1'b0;
        resp_err_s    = 1'b0;
        resp_data_s   = {DATA_WIDTH{1'b0}};
        case (state_r)
            IDLE: begin
                if (req != 2'b00) begin
                    grant_valid_s = 1'b1;
                    state_nxt_s   = ISSUE;
                    if (req[~last_grant_r]) begin
                        grant_nxt_s = ~last_grant_r;
                    end else begin
                        grant_nxt_s = last_grant_r;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                // A malformed select never reaches the bus; it is answered as an error.
                if (is_onehot(m_sel_r)) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = RESP;
                    resp_load_s = 1'b1;
                    resp_err_s  = 1'b1;
                end
            end
            WAIT: begin
                if (m_done) begin
                    state_nxt_s = RESP;
                    resp_load_s = 1'b1;
                    resp_err_s  = m_slverr;
                    resp_data_s = m_rdata;
                end else begin
`ifdef APB_ARB_TIMEOUT_EN
                    if (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_nxt_s = RESP;
                        resp_load_s = 1'b1;
                        resp_err_s  = 1'b1;
                    end else begin
                        state_nxt_s = WAIT;
                    end
`else
                    state_nxt_s = WAIT;
`endif
                end
            end
            RESP: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, latched request fields and all registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            grant_r      <= 1'b0;
            ack_r        <= 2'b00;
            rsp_rdata_r  <= {DATA_WIDTH{1'b0}};
            rsp_slverr_r <= 1'b0;
            busy_r       <= 1'b0;
            m_transfer_r <= 1'b0;
            m_addr_r     <= {ADDR_WIDTH{1'b0}};
            m_data_r     <= {DATA_WIDTH{1'b0}};
            m_write_r    <= 1'b0;
            m_sel_r      <= {SLAVES_NUM{1'b0}};
            m_strb_r     <= {STROBE_WIDTH{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            busy_r       <= (state_nxt_s != IDLE);
            m_transfer_r <= grant_valid_s & is_onehot(sel_mux_s);
            if (grant_valid_s) begin
                grant_r   <= grant_nxt_s;
                m_addr_r  <= addr_mux_s;
                m_data_r  <= wdata_mux_s;
                m_write_r <= write_mux_s;
                m_sel_r   <= sel_mux_s;
                m_strb_r  <= strb_mux_s;
            end
            if (resp_load_s) begin
                ack_r        <= grant_r ? 2'b10 : 2'b01;
                rsp_rdata_r  <= resp_data_s;
                rsp_slverr_r <= resp_err_s;
            end else begin
                ack_r <= 2'b00;
            end
            if (state_r == RESP) begin
                last_grant_r <= grant_r;
            end
        end
    end

    assign ack        = ack_r;
    assign rsp_rdata  = rsp_rdata_r;
    assign rsp_slverr = rsp_slverr_r;
    assign busy       = busy_r;
    assign m_Transfer = m_transfer_r;
    assign m_ADDR     = m_addr_r;
    assign m_DATA     = m_data_r;
    assign m_WRITE    = m_write_r;
    assign m_SEL      = m_sel_r;
    assign m_STROB    = m_strb_r;
    assign m_PROT     = 3'b000;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter: stimulus pushes expected transfers/acks, a monitor pops and compares.
module tb_apb_req_arbiter;

    logic        CLK, RST;
    logic [1:0]  req, req_write, ack;
    logic [63:0] req_addr, req_wdata;
    logic [3:0]  req_sel;
    logic [7:0]  req_strb;
    logic [31:0] rsp_rdata, m_ADDR, m_DATA, m_rdata;
    logic        rsp_slverr, busy, m_Transfer, m_WRITE, m_done, m_slverr;
    logic [1:0]  m_SEL;
    logic [3:0]  m_STROB;
    logic [2:0]  m_PROT;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct { logic [1:0] ack; logic [31:0] rdata; logic slverr; int cyc; } ack_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; logic write; logic [1:0] sel; logic [3:0] strb; int cyc; } xfer_t;
    ack_t  ack_q[$];
    xfer_t xfer_q[$];

    apb_req_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .STROBE_WIDTH(4), .SLAVES_NUM(2), .TIMEOUT_CYCLES(8)
    ) dut (
        .CLK(CLK), .RST(RST), .req(req), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_write(req_write), .req_sel(req_sel), .req_strb(req_strb), .ack(ack),
        .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr), .busy(busy), .m_Transfer(m_Transfer),
        .m_ADDR(m_ADDR), .m_DATA(m_DATA), .m_WRITE(m_WRITE), .m_SEL(m_SEL), .m_STROB(m_STROB),
        .m_PROT(m_PROT), .m_done(m_done), .m_rdata(m_rdata), .m_slverr(m_slverr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every presented transfer and ack against the scoreboard queues.
    initial begin
        logic        prev_xfer, prev_ack, in_xfer;
        logic [31:0] last_rdata;
        xfer_t       held, ex;
        ack_t        ea;
        prev_xfer = 1'b0; prev_ack = 1'b0; in_xfer = 1'b0; last_rdata = 32'h0;
        held = '{32'h0, 32'h0, 1'b0, 2'b00, 4'h0, 0};
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev_xfer = 1'b0; prev_ack = 1'b0; in_xfer = 1'b0; last_rdata = 32'h0;
            end else begin
                if (m_Transfer) begin
                    if (prev_xfer) chk("xfer_pulse_width", 64'd2, 64'd1);
                    if (xfer_q.size() == 0) begin
                        chk("unexpected_xfer", {32'h0, m_ADDR}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        ex = xfer_q.pop_front();
                        chk("xfer_cycle", 64'(cyc), 64'(ex.cyc));
                        chk("m_ADDR", {32'h0, m_ADDR}, {32'h0, ex.addr});
                        chk("m_DATA", {32'h0, m_DATA}, {32'h0, ex.data});
                        chk("m_WRITE", {63'h0, m_WRITE}, {63'h0, ex.write});
                        chk("m_SEL", {62'h0, m_SEL}, {62'h0, ex.sel});
                        chk("m_STROB", {60'h0, m_STROB}, {60'h0, ex.strb});
                        chk("busy_in_issue", {63'h0, busy}, 64'd1);
                        held = ex;
                        in_xfer = 1'b1;
                    end
                end else if (in_xfer && ack == 2'b00) begin
                    chk("wait_addr_hold", {32'h0, m_ADDR}, {32'h0, held.addr});
                    chk("wait_sel_hold", {62'h0, m_SEL}, {62'h0, held.sel});
                end
                if (ack != 2'b00) begin
                    if (prev_ack) chk("ack_pulse_width", 64'd2, 64'd1);
                    if (ack_q.size() == 0) begin
                        chk("unexpected_ack", {62'h0, ack}, 64'd0);
                    end else begin
                        ea = ack_q.pop_front();
                        chk("ack_cycle", 64'(cyc), 64'(ea.cyc));
                        chk("ack", {62'h0, ack}, {62'h0, ea.ack});
                        chk("rsp_rdata", {32'h0, rsp_rdata}, {32'h0, ea.rdata});
                        chk("rsp_slverr", {63'h0, rsp_slverr}, {63'h0, ea.slverr});
                        last_rdata = ea.rdata;
                    end
                    in_xfer = 1'b0;
                end else begin
                    chk("rsp_rdata_hold", {32'h0, rsp_rdata}, {32'h0, last_rdata});
                end
                prev_xfer = m_Transfer;
                prev_ack  = (ack != 2'b00);
            end
        end
    end

    // Waits for the issue pulse, answers it from WAIT and records the expected ack.
    task automatic serve(input bit bogus, input bit drop, input int extra,
                         input logic [31:0] rd, input logic se, input logic [1:0] exp_ack,
                         output int ack_cyc);
        int n;
        n = 0;
        @(negedge CLK);
        while (m_Transfer !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (m_Transfer !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL xfer_wait actual=no_pulse required=m_Transfer_pulse");
            ack_cyc = cyc;
            return;
        end
        if (drop) req = 2'b00;
        if (bogus) begin
            m_done = 1'b1; m_rdata = 32'hBAD0_BAD0; m_slverr = 1'b1;
        end
        @(posedge CLK); #1;
        m_done = 1'b0; m_rdata = 32'h0; m_slverr = 1'b0;
        repeat (extra) begin @(posedge CLK); #1; end
        m_done = 1'b1; m_rdata = rd; m_slverr = se;
        ack_cyc = cyc + 1;
        ack_q.push_back('{exp_ack, rd, se, ack_cyc});
        @(posedge CLK); #1;
        m_done = 1'b0; m_rdata = 32'h0; m_slverr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, a;
        RST = 1'b1; req = 2'b00; req_addr = 64'h0; req_wdata = 64'h0; req_write = 2'b00;
        req_sel = 4'h0; req_strb = 8'h0; m_done = 1'b0; m_rdata = 32'h0; m_slverr = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_ack", {62'h0, ack}, 64'd0);
        chk("reset_busy", {63'h0, busy}, 64'd0);
        chk("reset_xfer", {63'h0, m_Transfer}, 64'd0);
        chk("reset_m_ADDR", {32'h0, m_ADDR}, 64'd0);
        chk("reset_rsp", {31'h0, rsp_slverr, rsp_rdata}, 64'd0);
        chk("reset_m_PROT", {61'h0, m_PROT}, 64'd0);
        RST = 1'b0;
        @(posedge CLK); #1;

        // Both requesting: grants 0,1,0; requester 1 write, requester 0 later becomes a read.
        req_addr = {32'h0000_0004, 32'h0000_0100};
        req_wdata = {32'd15, 32'h0000_0011};
        req_write = 2'b11; req_sel = {2'b10, 2'b01}; req_strb = {4'hF, 4'h3};
        c = cyc;
        req = 2'b11;
        xfer_q.push_back('{32'h100, 32'h11, 1'b1, 2'b01, 4'h3, c + 1});
        serve(1'b1, 1'b0, 0, 32'h1234_5678, 1'b0, 2'b01, a);
        req_write = 2'b10;
        req_addr = {32'h0000_0004, 32'h0000_0200};
        xfer_q.push_back('{32'h4, 32'd15, 1'b1, 2'b10, 4'hF, a + 2});
        serve(1'b0, 1'b0, 0, 32'h0, 1'b0, 2'b10, a);
        xfer_q.push_back('{32'h200, 32'h11, 1'b0, 2'b01, 4'h3, a + 2});
`ifdef APB_ARB_TIMEOUT_EN
        serve(1'b0, 1'b1, 3, 32'hA5A5_A5A5, 1'b1, 2'b01, a);
`else
        serve(1'b0, 1'b1, 15, 32'hA5A5_A5A5, 1'b1, 2'b01, a);
`endif
        repeat (3) begin @(posedge CLK); #1; end
        chk("idle_busy", {63'h0, busy}, 64'd0);

        // Non-one-hot select: no bus transfer, error ack two cycles after sampling.
        req_sel = {2'b11, 2'b01};
        c = cyc;
        req = 2'b10;
        ack_q.push_back('{2'b10, 32'h0, 1'b1, c + 2});
        @(posedge CLK); #1;
        req = 2'b00;
        repeat (5) begin @(posedge CLK); #1; end
        req_sel = {2'b10, 2'b01};

`ifdef APB_ARB_TIMEOUT_EN
        // No m_done: error ack after 8 WAIT cycles.
        c = cyc;
        req = 2'b01;
        xfer_q.push_back('{32'h200, 32'h11, 1'b0, 2'b01, 4'h3, c + 1});
        ack_q.push_back('{2'b01, 32'h0, 1'b1, c + 10});
        @(posedge CLK); #1;
        req = 2'b00;
        repeat (14) begin @(posedge CLK); #1; end
`endif

        // Reset in WAIT: outputs clear at once, no ack, late m_done ignored.
        c = cyc;
        req = 2'b01;
        xfer_q.push_back('{32'h200, 32'h11, 1'b0, 2'b01, 4'h3, c + 1});
        @(posedge CLK); #1;
        req = 2'b00;
        @(posedge CLK); #1;
        @(posedge CLK); #3;
        RST = 1'b1;
        #1;
        chk("midwait_rst_busy", {63'h0, busy}, 64'd0);
        chk("midwait_rst_ack", {62'h0, ack}, 64'd0);
        chk("midwait_rst_m_ADDR", {32'h0, m_ADDR}, 64'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        m_done = 1'b1; m_rdata = 32'hDEAD_BEEF; m_slverr = 1'b1;
        @(posedge CLK); #1;
        m_done = 1'b0; m_rdata = 32'h0; m_slverr = 1'b0;
        repeat (4) begin @(posedge CLK); #1; end
        chk("post_rst_busy", {63'h0, busy}, 64'd0);
        chk("post_rst_rdata", {32'h0, rsp_rdata}, 64'd0);

        chk("xfer_q_drained", 64'(xfer_q.size()), 64'd0);
        chk("ack_q_drained", 64'(ack_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data width of the write data and read data buses.
REQ-002 Parameter ADDR_WIDTH, default 32: address width.
REQ-003 Parameter STROBE_WIDTH, default 4: write strobe width.
REQ-004 Parameter SLAVES_NUM, default 2: width of the slave-select vector (GPIO, UART).
REQ-005 Parameter TIMEOUT_CYCLES, default 255: WAIT-state cycle limit; used only when APB_ARB_TIMEOUT_EN is defined.
REQ-006 CLK  input  1  the single clock; all state changes on its rising edge.
REQ-007 RST  input  1  reset, asynchronous, active-high.
REQ-008 req  input  2  request per requester; bit i belongs to requester i.
REQ-009 req_addr  input  2*ADDR_WIDTH  per-requester address; requester i uses slice i.
REQ-010 req_wdata  input  2*DATA_WIDTH  per-requester write data.
REQ-011 req_write  input  2  per-requester direction; 1 = write.
REQ-012 req_sel  input  2*SLAVES_NUM  per-requester slave select; must be one-hot.
REQ-013 req_strb  input  2*STROBE_WIDTH  per-requester write strobes.
REQ-014 ack  output  2  one-cycle completion pulse per requester.
REQ-015 rsp_rdata  output  DATA_WIDTH  read data; valid while an ack bit is high.
REQ-016 rsp_slverr  output  1  error flag; valid while an ack bit is high.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 m_Transfer, m_ADDR, m_DATA, m_WRITE, m_SEL, m_STROB  outputs  1/ADDR/DATA/1/SLAVES_NUM/STROBE  drive the APB master's transfer inputs.
REQ-019 m_PROT  output  3  tied to 3'b000.
REQ-020 m_done, m_rdata, m_slverr  inputs  1/DATA/1  one-cycle master completion pulse, with read data and slave error.

Function
REQ-021 The block SHALL implement the FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, and every output SHALL be registered.
REQ-022 In IDLE, when any req bit is high, the block SHALL grant round-robin to the requester other than last_grant if it is requesting, otherwise to the sole requester.
REQ-023 On grant, the block SHALL latch that requester's addr, wdata, write, sel and strb, and go to ISSUE.
REQ-024 If the latched sel is not one-hot, the block SHALL skip ISSUE and WAIT, enter RESP with slverr=1 and rdata=0, and SHALL NOT assert m_Transfer.
REQ-025 In ISSUE, m_Transfer SHALL be high for exactly one cycle with the latched fields on the m_* outputs, then the FSM SHALL go to WAIT.
REQ-026 In WAIT, the m_* fields SHALL hold stable with m_Transfer low; on m_done=1 the block SHALL capture m_rdata and m_slverr and go to RESP.
REQ-027 m_done SHALL be ignored in every state except WAIT.
REQ-028 In RESP, the block SHALL pulse ack[grant] for one cycle with rsp_rdata and rsp_slverr, update last_grant, and return to IDLE.
REQ-029 Latency: a req sampled in IDLE at edge N SHALL give m_Transfer high in cycle N+1, and m_done at edge M SHALL give ack high in cycle M+1.
REQ-030 Minimum back-to-back spacing SHALL be 4 cycles from one grant to the next.
REQ-031 Deasserting req after grant SHALL NOT abort the transfer; ack SHALL still be issued.
REQ-032 When both requesters hold req continuously, grants SHALL strictly alternate 0,1,0,1.
REQ-033 When not in RESP, ack SHALL be 0 and rsp_rdata SHALL hold its last value.

Reset
REQ-034 RST high SHALL immediately force state IDLE, last_grant=1, ack=0, busy=0, m_Transfer=0, and all m_* data fields, rsp_rdata and rsp_slverr to 0.
REQ-035 A reset during WAIT SHALL abandon the transfer with no ack, and a subsequent m_done SHALL be ignored.

Configuration
REQ-036 With APB_ARB_TIMEOUT_EN defined, a WAIT-state counter SHALL run; at TIMEOUT_CYCLES without m_done the block SHALL go to RESP with slverr=1 and rdata=0.
REQ-037 Without APB_ARB_TIMEOUT_EN, WAIT SHALL persist until m_done, and no counter logic SHALL exist.

Verification
REQ-038 After reset, req=2'b11 held: grants 0,1,0; each m_Transfer is a 1-cycle pulse; each ack is one cycle after m_done.
REQ-039 Requester 1 writes addr 0x4, data 15, sel 2'b10, strb 4'hF: the m_* outputs match the latched values, and ack[1]=1 with slverr=0.
REQ-040 Requester 0 read, m_rdata=0xA5A5A5A5 and m_slverr=1 at m_done: rsp_rdata=0xA5A5A5A5 and rsp_slverr=1 with ack[0].
REQ-041 req_sel=2'b11: no m_Transfer, and ack with slverr=1 after 2 cycles.
REQ-042 With the macro defined, TIMEOUT_CYCLES=8 and no m_done: ack with slverr=1 after 8 WAIT cycles; RST asserted mid-WAIT gives busy=0 immediately and no ack.
